// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control FSM: opcodes, FSM states,
// immediate-format / PC-source / write-back selects, and opcode decode helpers.
package riscv_multicycle_ctrl_pkg;

    localparam int unsigned DATA_LEN = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned IMM_W    = 3;
    localparam int unsigned CNT_W    = 8;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OPC_ALUI   = 7'h13;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OPC_ALU    = 7'h33;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [IMM_W-1:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'b00,
        PC_PLUS_IMM = 2'b01,
        PC_ALU      = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'b00,
        ALU_A_PC   = 2'b01,
        ALU_A_ZERO = 2'b10
    } alu_a_e;

    // ALU operand routing for one opcode
    typedef struct packed {
        alu_a_e a_sel;
        logic   b_imm;
        logic   force_add;
    } alu_sel_t;

    // Full control-word payload driven towards the datapath
    typedef struct packed {
        logic      mem_req;
        logic      mem_we;
        logic      mem_is_instr;
        logic      ir_we;
        logic      pc_we;
        pc_src_e   pc_src;
        alu_a_e    alu_a_sel;
        logic      alu_b_sel;
        logic      alu_force_add;
        imm_type_e imm_type;
        logic      rf_we;
        wb_sel_e   wb_sel;
        logic      mem_timeout;
    } ctrl_t;

    function automatic imm_type_e imm_type_of(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_ALUI, OPC_LOAD, OPC_JALR: return IMM_I;
            OPC_STORE:                    return IMM_S;
            OPC_BRANCH:                   return IMM_B;
            OPC_LUI, OPC_AUIPC:           return IMM_U;
            OPC_JAL:                      return IMM_J;
            default:                      return IMM_NONE;
        endcase
    endfunction

    function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_ALU, OPC_ALUI, OPC_LUI, OPC_AUIPC, OPC_LOAD,
            OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic alu_sel_t alu_sel_of(input logic [OPC_W-1:0] opc);
        alu_sel_t s;
        s = '{a_sel: ALU_A_RS1, b_imm: 1'b0, force_add: 1'b0};
        case (opc)
            OPC_ALUI:            s.b_imm = 1'b1;
            OPC_LUI:             s = '{a_sel: ALU_A_ZERO, b_imm: 1'b1, force_add: 1'b1};
            OPC_AUIPC:           s = '{a_sel: ALU_A_PC,   b_imm: 1'b1, force_add: 1'b1};
            OPC_LOAD, OPC_STORE,
            OPC_JALR:            s = '{a_sel: ALU_A_RS1,  b_imm: 1'b1, force_add: 1'b1};
            default:             ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_wait_timer.sv
// riscv_mc_wait_timer: counts un-acked memory-request cycles and flags expiry.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : restart the count (state entry or retry)
//   i_inc        : one more un-acked request cycle
//   o_expired    : count has reached LIMIT (registered)
module riscv_mc_wait_timer
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q;

    // Clear has priority so a retry always restarts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == CNT_W'(LIMIT));
        end
    end

    assign o_expired = expired_q;

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath.
// Inputs : i_clk, i_rst (sync, active-high), i_instruction (IR), i_mem_ack,
//          i_branch_taken.
// Outputs: memory handshake (o_mem_req/we/is_instr), PC/IR/regfile enables,
//          PC source, ALU operand selects, immediate format, write-back select,
//          o_mem_timeout, o_state (debug).
// WAIT_LIMIT > 0 adds a request timeout with retry (riscv_mc_wait_timer).
// Build option RISCV_MC_ILLEGAL_TRAP_EN: illegal opcodes park in TRAP and raise
// o_illegal; without it they retire as a NOP.
module riscv_multicycle_ctrl
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DATA_LEN-1:0] i_instruction,
    input  logic                i_mem_ack,
    input  logic                i_branch_taken,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic                o_mem_is_instr,
    output logic                o_ir_we,
    output logic                o_pc_we,
    output logic [1:0]          o_pc_src,
    output logic [1:0]          o_alu_a_sel,
    output logic                o_alu_b_sel,
    output logic                o_alu_force_add,
    output logic [2:0]          o_imm_type,
    output logic                o_rf_we,
    output logic [1:0]          o_wb_sel,
    output logic                o_mem_timeout,
    output logic [2:0]          o_state
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    ,
    output logic                o_illegal
`endif
);

    state_e           state_q, state_d;
    ctrl_t            c, c_o;
    alu_sel_t         alu;
    logic [OPC_W-1:0] opcode;
    logic [4:0]       rd;
    logic             tmr_expired;
    logic             unused_instr;

    assign opcode       = i_instruction[OPC_W-1:0];
    assign rd           = i_instruction[11:7];
    assign alu          = alu_sel_of(opcode);
    assign unused_instr = ^i_instruction[DATA_LEN-1:12];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control word
    always_comb begin
        state_d = state_q;
        c       = '0;

        // Operand routing stays stable through EXEC/MEM/WB so the ALU result
        // (address, JALR target) remains valid until it is consumed.
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            c.imm_type = imm_type_of(opcode);
        end
        if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
            c.alu_a_sel     = alu.a_sel;
            c.alu_b_sel     = alu.b_imm;
            c.alu_force_add = alu.force_add;
        end

        case (state_q)
            ST_FETCH: begin
                if (tmr_expired) begin
                    c.mem_timeout = 1'b1;  // request gap, then retry FETCH
                end else begin
                    c.mem_req      = 1'b1;
                    c.mem_is_instr = 1'b1;
                    if (i_mem_ack) begin
                        c.ir_we = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (opc_is_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    c.pc_we  = 1'b1;
                    c.pc_src = PC_PLUS4;
                    state_d  = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_BRANCH: begin
                        c.pc_we  = 1'b1;
                        c.pc_src = i_branch_taken ? PC_PLUS_IMM : PC_PLUS4;
                        state_d  = ST_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (tmr_expired) begin
                    c.mem_timeout = 1'b1;
                end else begin
                    c.mem_req = 1'b1;
                    c.mem_we  = (opcode == OPC_STORE);
                    if (i_mem_ack) begin
                        if (opcode == OPC_STORE) begin
                            c.pc_we  = 1'b1;
                            c.pc_src = PC_PLUS4;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
            end
            ST_WB: begin
                c.rf_we = (rd != 5'd0);
                c.pc_we = 1'b1;
                case (opcode)
                    OPC_JAL: begin
                        c.pc_src = PC_PLUS_IMM;
                        c.wb_sel = WB_PC4;
                    end
                    OPC_JALR: begin
                        c.pc_src = PC_ALU;
                        c.wb_sel = WB_PC4;
                    end
                    OPC_LOAD: c.wb_sel = WB_MEM;
                    default:  ;
                endcase
                state_d = ST_FETCH;
            end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;  // only reset leaves TRAP
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // Request timeout, present only when a limit is configured
    generate
        if (WAIT_LIMIT > 0) begin : g_timer
            logic tmr_clr, tmr_inc;
            assign tmr_clr = (state_d != state_q) || tmr_expired;
            assign tmr_inc = c.mem_req && !i_mem_ack;
            riscv_mc_wait_timer #(
                .LIMIT (WAIT_LIMIT)
            ) u_timer (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_clr     (tmr_clr),
                .i_inc     (tmr_inc),
                .o_expired (tmr_expired)
            );
        end else begin : g_no_timer
            assign tmr_expired = 1'b0;
        end
    endgenerate

    // Everything reads as zero while reset is held
    assign c_o             = i_rst ? '0 : c;
    assign o_mem_req       = c_o.mem_req;
    assign o_mem_we        = c_o.mem_we;
    assign o_mem_is_instr  = c_o.mem_is_instr;
    assign o_ir_we         = c_o.ir_we;
    assign o_pc_we         = c_o.pc_we;
    assign o_pc_src        = c_o.pc_src;
    assign o_alu_a_sel     = c_o.alu_a_sel;
    assign o_alu_b_sel     = c_o.alu_b_sel;
    assign o_alu_force_add = c_o.alu_force_add;
    assign o_imm_type      = c_o.imm_type;
    assign o_rf_we         = c_o.rf_we;
    assign o_wb_sel        = c_o.wb_sel;
    assign o_mem_timeout   = c_o.mem_timeout;
    assign o_state         = i_rst ? 3'd0 : state_q;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    assign o_illegal       = !i_rst && (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: one instance with WAIT_LIMIT=0 for
// the instruction sequences, one with WAIT_LIMIT=4 for fetch timeout/retry.
module tb_riscv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, rst_w, ack, ack_w, taken;
    logic [31:0] instr;

    logic        mem_req, mem_we, mem_is_instr, ir_we, pc_we, alu_b_sel, alu_force_add;
    logic        rf_we, mem_timeout;
    logic [1:0]  pc_src, alu_a_sel, wb_sel;
    logic [2:0]  imm_type, state;
    logic        w_mem_req, w_mem_we, w_mem_is_instr, w_ir_we, w_pc_we, w_alu_b_sel;
    logic        w_alu_force_add, w_rf_we, w_mem_timeout;
    logic [1:0]  w_pc_src, w_alu_a_sel, w_wb_sel;
    logic [2:0]  w_imm_type, w_state;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    logic        illegal, w_illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_instruction(instr), .i_mem_ack(ack),
        .i_branch_taken(taken), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_is_instr(mem_is_instr), .o_ir_we(ir_we), .o_pc_we(pc_we),
        .o_pc_src(pc_src), .o_alu_a_sel(alu_a_sel), .o_alu_b_sel(alu_b_sel),
        .o_alu_force_add(alu_force_add), .o_imm_type(imm_type), .o_rf_we(rf_we),
        .o_wb_sel(wb_sel), .o_mem_timeout(mem_timeout), .o_state(state)
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        , .o_illegal(illegal)
`endif
    );

    riscv_multicycle_ctrl #(.WAIT_LIMIT(4)) dut_w (
        .i_clk(clk), .i_rst(rst_w), .i_instruction(instr), .i_mem_ack(ack_w),
        .i_branch_taken(taken), .o_mem_req(w_mem_req), .o_mem_we(w_mem_we),
        .o_mem_is_instr(w_mem_is_instr), .o_ir_we(w_ir_we), .o_pc_we(w_pc_we),
        .o_pc_src(w_pc_src), .o_alu_a_sel(w_alu_a_sel), .o_alu_b_sel(w_alu_b_sel),
        .o_alu_force_add(w_alu_force_add), .o_imm_type(w_imm_type), .o_rf_we(w_rf_we),
        .o_wb_sel(w_wb_sel), .o_mem_timeout(w_mem_timeout), .o_state(w_state)
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        , .o_illegal(w_illegal)
`endif
    );

    // {state, req, we, is_instr, ir_we, pc_we, pc_src, a_sel, b_sel, force_add,
    //  imm_type, rf_we, wb_sel, timeout}
    logic [20:0] outs, w_outs;
    assign outs   = {state, mem_req, mem_we, mem_is_instr, ir_we, pc_we, pc_src,
                     alu_a_sel, alu_b_sel, alu_force_add, imm_type, rf_we, wb_sel, mem_timeout};
    assign w_outs = {w_state, w_mem_req, w_mem_we, w_mem_is_instr, w_ir_we, w_pc_we, w_pc_src,
                     w_alu_a_sel, w_alu_b_sel, w_alu_force_add, w_imm_type, w_rf_we, w_wb_sel,
                     w_mem_timeout};

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
    // {req, we, is_instr}
    localparam logic [2:0] M_NO = 3'b000, M_IF = 3'b101, M_LD = 3'b100, M_ST = 3'b110;
    // {a_sel, b_sel, force_add}
    localparam logic [3:0] A_RR = 4'b0000, A_RI = 4'b0010, A_ADD = 4'b0011, A_LUI = 4'b1011;

    function automatic logic [20:0] mk(input logic [2:0] st, input logic [2:0] mem,
                                       input logic irwe, input logic pcwe,
                                       input logic [1:0] src, input logic [3:0] alu,
                                       input logic [2:0] imm, input logic rfwe,
                                       input logic [1:0] wbs, input logic to);
        return {st, mem, irwe, pcwe, src, alu, imm, rfwe, wbs, to};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, sample, advance one cycle
    task automatic cyc(input string tag, input logic a, input logic t, input logic [20:0] exp);
        ack   = a;
        taken = t;
        #1;
        check(tag, 32'(outs), 32'(exp));
        @(negedge clk);
    endtask

    task automatic cyc_w(input string tag, input logic a, input logic [20:0] exp);
        ack_w = a;
        #1;
        check(tag, 32'(w_outs), 32'(exp));
        @(negedge clk);
    endtask

    task automatic fetch(input string tag, input logic [31:0] ins);
        instr = ins;
        cyc(tag, 1'b1, 1'b0, mk(S_F, M_IF, 1, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
    endtask

    localparam logic [20:0] ZERO = 21'd0;

    initial begin
        rst = 1'b1; rst_w = 1'b1; ack = 1'b0; ack_w = 1'b0; taken = 1'b0; instr = 32'h0;
        @(negedge clk);
        cyc("reset_a", 1'b1, 1'b0, ZERO);
        cyc("reset_b", 1'b0, 1'b0, ZERO);
        rst = 1'b0;

        // Fetch holds request until ack
        cyc("fetch_wait", 1'b0, 1'b0, mk(S_F, M_IF, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));

        // ADDI x1,x0,5
        fetch("addi_fetch", 32'h00500093);
        cyc("addi_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd1, 0, 2'b00, 0));
        cyc("addi_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_RI, 3'd1, 0, 2'b00, 0));
        cyc("addi_wb",   0, 0, mk(S_W, M_NO, 0, 1, 2'b00, A_RI, 3'd1, 1, 2'b00, 0));

        // LW x2,8(x1), data ack after 3 cycles
        fetch("lw_fetch", 32'h0080A103);
        cyc("lw_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR,  3'd1, 0, 2'b00, 0));
        cyc("lw_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        cyc("lw_mem1", 0, 0, mk(S_M, M_LD, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        cyc("lw_mem2", 0, 0, mk(S_M, M_LD, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        cyc("lw_mem3", 1, 0, mk(S_M, M_LD, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        cyc("lw_wb",   0, 0, mk(S_W, M_NO, 0, 1, 2'b00, A_ADD, 3'd1, 1, 2'b01, 0));

        // SW x2,4(x1), ack same cycle
        fetch("sw_fetch", 32'h0020A223);
        cyc("sw_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR,  3'd2, 0, 2'b00, 0));
        cyc("sw_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_ADD, 3'd2, 0, 2'b00, 0));
        cyc("sw_mem",  1, 0, mk(S_M, M_ST, 0, 1, 2'b00, A_ADD, 3'd2, 0, 2'b00, 0));

        // BEQ taken then not taken
        fetch("beq_t_fetch", 32'h00000463);
        cyc("beq_t_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd3, 0, 2'b00, 0));
        cyc("beq_t_exec", 0, 1, mk(S_E, M_NO, 0, 1, 2'b01, A_RR, 3'd3, 0, 2'b00, 0));
        fetch("beq_n_fetch", 32'h00000463);
        cyc("beq_n_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd3, 0, 2'b00, 0));
        cyc("beq_n_exec", 0, 0, mk(S_E, M_NO, 0, 1, 2'b00, A_RR, 3'd3, 0, 2'b00, 0));

        // LUI x3,0x12345
        fetch("lui_fetch", 32'h123451B7);
        cyc("lui_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR,  3'd4, 0, 2'b00, 0));
        cyc("lui_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_LUI, 3'd4, 0, 2'b00, 0));
        cyc("lui_wb",   0, 0, mk(S_W, M_NO, 0, 1, 2'b00, A_LUI, 3'd4, 1, 2'b00, 0));

        // ADD x3,x1,x2
        fetch("add_fetch", 32'h002081B3);
        cyc("add_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        cyc("add_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        cyc("add_wb",   0, 0, mk(S_W, M_NO, 0, 1, 2'b00, A_RR, 3'd0, 1, 2'b00, 0));

        // JAL x0 (rd=0, no rf write)
        fetch("jal_fetch", 32'h0000006F);
        cyc("jal_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd5, 0, 2'b00, 0));
        cyc("jal_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_RR, 3'd5, 0, 2'b00, 0));
        cyc("jal_wb",   0, 0, mk(S_W, M_NO, 0, 1, 2'b01, A_RR, 3'd5, 0, 2'b10, 0));

        // JALR x1,0(x2)
        fetch("jalr_fetch", 32'h000100E7);
        cyc("jalr_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR,  3'd1, 0, 2'b00, 0));
        cyc("jalr_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        cyc("jalr_wb",   0, 0, mk(S_W, M_NO, 0, 1, 2'b10, A_ADD, 3'd1, 1, 2'b10, 0));

        // Reset during a load's MEM wait: no writes, restart at FETCH
        fetch("rlw_fetch", 32'h0080A103);
        cyc("rlw_dec",  0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR,  3'd1, 0, 2'b00, 0));
        cyc("rlw_exec", 0, 0, mk(S_E, M_NO, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        cyc("rlw_mem",  0, 0, mk(S_M, M_LD, 0, 0, 2'b00, A_ADD, 3'd1, 0, 2'b00, 0));
        rst = 1'b1;
        cyc("rlw_rst",  1, 0, ZERO);
        rst = 1'b0;
        cyc("rlw_refetch", 0, 0, mk(S_F, M_IF, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));

        // Illegal opcode 0x7F
        fetch("ill_fetch", 32'h0000007F);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        cyc("ill_dec",   0, 0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        #1 check("ill_flag_a", 32'(illegal), 32'd1);
        cyc("ill_trap_a", 1, 0, mk(S_T, M_NO, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        #1 check("ill_flag_b", 32'(illegal), 32'd1);
        cyc("ill_trap_b", 0, 0, mk(S_T, M_NO, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        rst = 1'b1;
        #1 check("ill_flag_rst", 32'(illegal), 32'd0);
        cyc("ill_rst", 0, 0, ZERO);
        rst = 1'b0;
        cyc("ill_refetch", 0, 0, mk(S_F, M_IF, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
`else
        cyc("ill_dec",   0, 0, mk(S_D, M_NO, 0, 1, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        cyc("ill_refetch", 0, 0, mk(S_F, M_IF, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
`endif

        // WAIT_LIMIT=4: timeout after 4 un-acked req cycles, 1-cycle gap, retry;
        // ack on the 4th retry cycle wins
        cyc_w("w_reset", 0, ZERO);
        rst_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_w($sformatf("w_req%0d", i), 0, mk(S_F, M_IF, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        end
        cyc_w("w_timeout", 0, mk(S_F, M_NO, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 1));
        for (int i = 0; i < 3; i++) begin
            cyc_w($sformatf("w_retry%0d", i), 0, mk(S_F, M_IF, 0, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        end
        instr = 32'h00500093;
        cyc_w("w_ack_limit", 1, mk(S_F, M_IF, 1, 0, 2'b00, A_RR, 3'd0, 0, 2'b00, 0));
        cyc_w("w_decode",    0, mk(S_D, M_NO, 0, 0, 2'b00, A_RR, 3'd1, 0, 2'b00, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
